// File: rtl/player_bullet_scheduler.sv
// Player shot scheduler: owns a small pool of bullet slots. On each movement
// tick it moves every live shot upward and retires shots that leave the top
// edge. A new shot goes into the lowest free slot, but only when the cooldown
// has expired. Hits and clear free slots. Every output is registered.
module player_bullet_scheduler #(
  parameter int SLOTS     = 4,
  parameter int COOLDOWN  = 8,
  parameter int SPEED     = 4,
  parameter int SPAWN_OFS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  shoot,
  input  logic                  clear,
  input  logic [9:0]            player_x,
  input  logic [9:0]            player_y,
  input  logic [SLOTS-1:0]      hit_mask,
  output logic [SLOTS-1:0]      bullet_valid,
  output logic [10*SLOTS-1:0]   bullet_x,
  output logic [10*SLOTS-1:0]   bullet_y,
  output logic                  fire_pulse,
  output logic [3:0]            active_count
);

  localparam logic [9:0] SPEED_V   = 10'(SPEED);
  localparam logic [9:0] SPAWN_V   = 10'(SPAWN_OFS);
  localparam logic [7:0] CD_RELOAD = 8'(COOLDOWN - 1);

  typedef enum logic {READY, COOL} state_t;

  state_t           state_reg, state_next;
  logic [7:0]       cd_reg, cd_next;
  logic [SLOTS-1:0] valid_reg, valid_next;
  logic [9:0]       x_reg [SLOTS];
  logic [9:0]       x_next [SLOTS];
  logic [9:0]       y_reg [SLOTS];
  logic [9:0]       y_next [SLOTS];
  logic             fire_reg, fire_next;
  logic [3:0]       count_reg, count_next;

  // The lowest free slot, taken from the occupancy at the start of the cycle.
  // A slot freed in this cycle therefore cannot be reused until a later tick.
  logic [SLOTS-1:0] free_onehot;
  logic             launch;

  // Pick the lowest free slot and decide whether a shot launches this cycle.
  always_comb begin
    free_onehot = ~valid_reg & (valid_reg + 1'b1);
    launch      = tick && shoot && !clear && (state_reg == READY) &&
                  (|free_onehot) && (player_y >= SPAWN_V);
  end

  // Next-state logic: clear has top priority, then hits, then movement, then launch.
  always_comb begin
    state_next = state_reg;
    cd_next    = cd_reg;
    valid_next = valid_reg;
    fire_next  = 1'b0;
    count_next = '0;
    for (int i = 0; i < SLOTS; i++) begin
      x_next[i] = x_reg[i];
      y_next[i] = y_reg[i];
    end

    if (clear) begin
      valid_next = '0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (valid_reg[i]) begin
          if (hit_mask[i]) begin
            valid_next[i] = 1'b0;
          end else if (tick) begin
            // Compare before subtracting so that y never wraps around.
            if (y_reg[i] < SPEED_V) valid_next[i] = 1'b0;
            else                    y_next[i]     = y_reg[i] - SPEED_V;
          end
        end else if (launch && free_onehot[i]) begin
          valid_next[i] = 1'b1;
          x_next[i]     = player_x;
          y_next[i]     = player_y - SPAWN_V;
        end
      end

      // The cooldown counts down on ticks only. The tick that reaches zero never launches.
      if (tick && (state_reg == COOL)) begin
        cd_next = cd_reg - 8'd1;
        if (cd_reg == 8'd1) state_next = READY;
      end

      if (launch) begin
        fire_next  = 1'b1;
        cd_next    = CD_RELOAD;
        state_next = (COOLDOWN == 1) ? READY : COOL;
      end
    end

    for (int i = 0; i < SLOTS; i++) count_next = count_next + 4'(valid_next[i]);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= READY;
      cd_reg    <= '0;
      valid_reg <= '0;
      fire_reg  <= 1'b0;
      count_reg <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        x_reg[i] <= '0;
        y_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      cd_reg    <= cd_next;
      valid_reg <= valid_next;
      fire_reg  <= fire_next;
      count_reg <= count_next;
      for (int i = 0; i < SLOTS; i++) begin
        x_reg[i] <= x_next[i];
        y_reg[i] <= y_next[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_pack
      assign bullet_x[10*gi +: 10] = x_reg[gi];
      assign bullet_y[10*gi +: 10] = y_reg[gi];
    end
  endgenerate

  assign bullet_valid = valid_reg;
  assign fire_pulse   = fire_reg;
  assign active_count = count_reg;

endmodule

// File: tb/tb_player_bullet_scheduler.sv
// Directed test of player_bullet_scheduler with its default parameters.
module tb_player_bullet_scheduler;
  localparam int SLOTS = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                tick = 1'b0;
  logic                shoot = 1'b0;
  logic                clear = 1'b0;
  logic [9:0]          player_x = '0;
  logic [9:0]          player_y = '0;
  logic [SLOTS-1:0]    hit_mask = '0;
  logic [SLOTS-1:0]    bullet_valid;
  logic [10*SLOTS-1:0] bullet_x;
  logic [10*SLOTS-1:0] bullet_y;
  logic                fire_pulse;
  logic [3:0]          active_count;

  int   total = 0;
  int   bad = 0;
  int   pulses = 0;
  logic last_fire = 1'b0;

  player_bullet_scheduler #(.SLOTS(4), .COOLDOWN(8), .SPEED(4), .SPAWN_OFS(16)) dut (
    .clk(clk), .rst(rst), .tick(tick), .shoot(shoot), .clear(clear),
    .player_x(player_x), .player_y(player_y), .hit_mask(hit_mask),
    .bullet_valid(bullet_valid), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .fire_pulse(fire_pulse), .active_count(active_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] xof(input int i);
    return bullet_x[10*i +: 10];
  endfunction

  function automatic logic [9:0] yof(input int i);
    return bullet_y[10*i +: 10];
  endfunction

  task automatic clk1();
    @(posedge clk);
    #1;
    if (fire_pulse === 1'b1) pulses++;
  endtask

  // One tick cycle, followed by one idle cycle. last_fire holds the pulse seen after the tick edge.
  task automatic do_tick(input logic sh, input logic [SLOTS-1:0] hm, input logic cl);
    tick = 1'b1; shoot = sh; hit_mask = hm; clear = cl;
    clk1();
    last_fire = fire_pulse;
    tick = 1'b0; hit_mask = '0; clear = 1'b0;
    clk1();
  endtask

  initial begin
    // Reset held while tick, shoot and hits are active.
    rst = 1'b0; tick = 1'b1; shoot = 1'b1; hit_mask = 4'hF;
    player_x = 10'd320; player_y = 10'd400;
    repeat (3) clk1();
    chk("rst_valid", 32'(bullet_valid), 0);
    chk("rst_fire", 32'(fire_pulse), 0);
    chk("rst_count", 32'(active_count), 0);
    chk("rst_x", 32'(bullet_x), 0);
    chk("rst_y", 32'(bullet_y), 0);
    rst = 1'b1; tick = 1'b0; hit_mask = '0;
    clk1();
    chk("shoot_no_tick_valid", 32'(bullet_valid), 0);
    chk("shoot_no_tick_fire", 32'(fire_pulse), 0);
    pulses = 0;

    // Hold shoot for 40 ticks: launches on ticks 1, 9, 17 and 25, then the pool is full.
    for (int t = 1; t <= 40; t++) begin
      do_tick(1'b1, '0, 1'b0);
      chk($sformatf("launch_t%0d", t), 32'(last_fire),
          32'((t == 1) || (t == 9) || (t == 17) || (t == 25)));
      if (t == 1) begin
        chk("first_valid", 32'(bullet_valid), 32'h1);
        chk("first_x", 32'(xof(0)), 320);
        chk("first_y", 32'(yof(0)), 384);
        chk("first_count", 32'(active_count), 1);
        chk("pulse_one_clk", 32'(fire_pulse), 0);
      end
      if (t == 9)  chk("t9_valid", 32'(bullet_valid), 32'h3);
      if (t == 17) chk("t17_valid", 32'(bullet_valid), 32'h7);
    end
    chk("pulse_count40", 32'(pulses), 4);
    chk("full_valid", 32'(bullet_valid), 32'hF);
    chk("full_count", 32'(active_count), 4);
    chk("slot0_y_t40", 32'(yof(0)), 228);
    chk("slot3_y_t40", 32'(yof(3)), 324);

    // A hit frees slot 0 on a READY tick with shoot held. The freed slot is not reused this tick.
    do_tick(1'b1, 4'b0001, 1'b0);
    chk("hit_no_launch", 32'(last_fire), 0);
    chk("hit_valid", 32'(bullet_valid), 32'hE);
    chk("hit_count", 32'(active_count), 3);
    chk("hit_slot1_y", 32'(yof(1)), 256);
    chk("hit_slot0_y_kept", 32'(yof(0)), 228);
    player_x = 10'd100;
    do_tick(1'b1, '0, 1'b0);
    chk("relaunch_fire", 32'(last_fire), 1);
    chk("relaunch_valid", 32'(bullet_valid), 32'hF);
    chk("relaunch_x", 32'(xof(0)), 100);
    chk("relaunch_y", 32'(yof(0)), 384);

    // A hit outside a tick still frees the slot and leaves its position alone.
    shoot = 1'b0; hit_mask = 4'b0010;
    clk1();
    hit_mask = '0;
    chk("offtick_hit_valid", 32'(bullet_valid), 32'hD);
    chk("offtick_hit_count", 32'(active_count), 3);
    chk("offtick_hit_y1", 32'(yof(1)), 252);

    // Clear wins over tick, shoot and hits. The cooldown (7) must not move on that tick.
    do_tick(1'b1, 4'hF, 1'b1);
    chk("clear_valid", 32'(bullet_valid), 0);
    chk("clear_count", 32'(active_count), 0);
    chk("clear_fire", 32'(last_fire), 0);
    for (int a = 1; a <= 8; a++) begin
      do_tick(1'b1, '0, 1'b0);
      chk($sformatf("cd_after_clear_a%0d", a), 32'(last_fire), 32'(a == 8));
    end
    chk("post_clear_valid", 32'(bullet_valid), 32'h1);

    // Let the cooldown expire, then clear the pool without a tick.
    for (int b = 1; b <= 8; b++) do_tick(1'b0, '0, 1'b0);
    clear = 1'b1;
    clk1();
    clear = 1'b0;
    chk("clear_idle_valid", 32'(bullet_valid), 0);

    // Retirement off the top edge: y goes 10, 6, 2 and then the slot frees with no wrap.
    player_x = 10'd50; player_y = 10'd26;
    do_tick(1'b1, '0, 1'b0);
    chk("ret_fire", 32'(last_fire), 1);
    chk("ret_y10", 32'(yof(0)), 10);
    chk("ret_x", 32'(xof(0)), 50);
    do_tick(1'b0, '0, 1'b0);
    chk("ret_y6", 32'(yof(0)), 6);
    do_tick(1'b0, '0, 1'b0);
    chk("ret_y2", 32'(yof(0)), 2);
    chk("ret_valid_before", 32'(bullet_valid), 32'h1);
    do_tick(1'b0, '0, 1'b0);
    chk("ret_valid_after", 32'(bullet_valid), 0);
    chk("ret_y_no_wrap", 32'(yof(0)), 2);
    chk("ret_count", 32'(active_count), 0);
    for (int c = 1; c <= 4; c++) do_tick(1'b0, '0, 1'b0);

    // Spawn guard: player_y below the offset blocks the launch. Exactly at the offset, it launches at y=0.
    player_y = 10'd10;
    do_tick(1'b1, '0, 1'b0);
    chk("guard_fire", 32'(last_fire), 0);
    chk("guard_valid", 32'(bullet_valid), 0);
    player_y = 10'd16;
    do_tick(1'b1, '0, 1'b0);
    chk("edge_fire", 32'(last_fire), 1);
    chk("edge_y0", 32'(yof(0)), 0);
    chk("edge_count", 32'(active_count), 1);
    do_tick(1'b0, '0, 1'b0);
    chk("edge_retire_valid", 32'(bullet_valid), 0);
    chk("edge_retire_y", 32'(yof(0)), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Time limit so that the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout reached before the end of the sequence");
    $fatal(1, "timeout");
  end
endmodule
